apb_event_sync: RTL and testbench



---
 rtl/apb_event_sync_pkg.sv | 13 +
 rtl/event_edge_sync.sv | 46 ++++
 rtl/apb_event_sync.sv | 105 ++++++++++
 tb/tb_apb_event_sync.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_event_sync_pkg.sv
// Register map shared by the APB event synchroniser and anything that programs it.
// Offsets are word indices taken from PADDR[4:2].
package apb_event_sync_pkg;

   localparam int unsigned REG_IDX_W = 3;

   localparam logic [REG_IDX_W-1:0] REG_RISE_EN = 3'd0;  // 0x00
   localparam logic [REG_IDX_W-1:0] REG_FALL_EN = 3'd1;  // 0x04
   localparam logic [REG_IDX_W-1:0] REG_PENDING = 3'd2;  // 0x08
   localparam logic [REG_IDX_W-1:0] REG_SWSET   = 3'd3;  // 0x0C
   localparam logic [REG_IDX_W-1:0] REG_LEVEL   = 3'd4;  // 0x10

endpackage

// File: rtl/event_edge_sync.sv
// Per-line multi-flop synchroniser followed by a one-cycle history flop, giving
// unqualified rising/falling edge strobes on the synchronised level.
module event_edge_sync #(
   parameter int unsigned N_LINES     = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic [N_LINES-1:0] async_i,
   output logic [N_LINES-1:0] sync_o,
   output logic [N_LINES-1:0] rise_raw_o,
   output logic [N_LINES-1:0] fall_raw_o
);

   logic [N_LINES-1:0] prev_q;

   genvar gi;
   generate
      for (gi = 0; gi < N_LINES; gi++) begin : g_line
         // Bit 0 is the metastability-catching stage; the MSB is the usable level.
         logic [SYNC_STAGES-1:0] chain_q;

         always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
               chain_q <= '0;
            end else begin
               chain_q <= {chain_q[SYNC_STAGES-2:0], async_i[gi]};
            end
         end

         assign sync_o[gi] = chain_q[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         prev_q <= '0;
      end else begin
         prev_q <= sync_o;
      end
   end

   assign rise_raw_o = sync_o & ~prev_q;
   assign fall_raw_o = ~sync_o & prev_q;

endmodule

// File: rtl/apb_event_sync.sv
// APB-programmable edge detector for asynchronous event lines: enables, sticky
// PENDING (irq_o) and a registered one-cycle event_o pulse per detected edge.
module apb_event_sync
   import apb_event_sync_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned N_LINES        = 32,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic [N_LINES-1:0]        evt_async_i,
   output logic [N_LINES-1:0]        event_o,
   output logic [N_LINES-1:0]        irq_o
);

   logic [N_LINES-1:0]   rise_en_q, rise_en_d;
   logic [N_LINES-1:0]   fall_en_q, fall_en_d;
   logic [N_LINES-1:0]   pending_q, pending_d;
   logic [N_LINES-1:0]   event_q, event_d;

   logic [N_LINES-1:0]   sync_lvl, rise_raw, fall_raw;
   logic [N_LINES-1:0]   hw_evt, sw_set, w1c;
   logic [N_LINES-1:0]   wdata_n, rdata_n;
   logic [REG_IDX_W-1:0] reg_idx;
   logic                 wr_en;
   logic                 bus_unused;

   event_edge_sync #(
      .N_LINES     (N_LINES),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .async_i    (evt_async_i),
      .sync_o     (sync_lvl),
      .rise_raw_o (rise_raw),
      .fall_raw_o (fall_raw)
   );

   assign reg_idx    = PADDR[4:2];
   assign wr_en      = PSEL & PENABLE & PWRITE;
   assign wdata_n    = PWDATA[N_LINES-1:0];
   assign bus_unused = ^{PADDR, PWDATA};

   assign hw_evt = (rise_raw & rise_en_q) | (fall_raw & fall_en_q);
   assign sw_set = (wr_en && reg_idx == REG_SWSET)   ? wdata_n : '0;
   assign w1c    = (wr_en && reg_idx == REG_PENDING) ? wdata_n : '0;

   always_comb begin
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      if (wr_en && reg_idx == REG_RISE_EN) begin
         rise_en_d = wdata_n;
      end
      if (wr_en && reg_idx == REG_FALL_EN) begin
         fall_en_d = wdata_n;
      end
      // New events win over a simultaneous clear so nothing is dropped.
      pending_d = (pending_q & ~w1c) | hw_evt | sw_set;
      event_d   = hw_evt | sw_set;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rise_en_q <= '0;
         fall_en_q <= '0;
         pending_q <= '0;
         event_q   <= '0;
      end else begin
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pending_q <= pending_d;
         event_q   <= event_d;
      end
   end

   always_comb begin
      rdata_n = '0;
      if (PSEL) begin
         case (reg_idx)
            REG_RISE_EN: rdata_n = rise_en_q;
            REG_FALL_EN: rdata_n = fall_en_q;
            REG_PENDING: rdata_n = pending_q;
            REG_LEVEL:   rdata_n = sync_lvl;
            default:     rdata_n = '0;
         endcase
      end
   end

   assign PRDATA  = 32'(rdata_n);
   assign PREADY  = 1'b1;
   assign PSLVERR = 1'b0;
   assign event_o = event_q;
   assign irq_o   = pending_q;

endmodule

// File: tb/tb_apb_event_sync.sv
// Bench for apb_event_sync: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a delay-line reference model.
module tb_apb_event_sync;

   localparam int AW = 12;
   localparam int N  = 32;
   localparam int S  = 2;

   logic          HCLK    = 1'b0;
   logic          HRESETn = 1'b0;
   logic [AW-1:0] PADDR   = '0;
   logic [31:0]   PWDATA  = '0;
   logic          PWRITE  = 1'b0;
   logic          PSEL    = 1'b0;
   logic          PENABLE = 1'b0;
   logic [31:0]   PRDATA;
   logic          PREADY;
   logic          PSLVERR;
   logic [N-1:0]  evt     = '0;
   logic [N-1:0]  event_o;
   logic [N-1:0]  irq_o;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;
   int pcnt [N];

   apb_event_sync #(
      .APB_ADDR_WIDTH (AW),
      .N_LINES        (N),
      .SYNC_STAGES    (S)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PWRITE      (PWRITE),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR),
      .evt_async_i (evt),
      .event_o     (event_o),
      .irq_o       (irq_o)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: input samples per clock edge in a queue (newest first);
   // the synchronised level is the sample taken S-1 edges ago, prev one edge older.
   logic [N-1:0] m_rise, m_fall, m_pend, m_evt;
   logic [N-1:0] m_hist [$];

   function automatic logic [31:0] m_read(input logic [AW-1:0] a);
      case (a[4:2])
         3'd0:    return m_rise;
         3'd1:    return m_fall;
         3'd2:    return m_pend;
         3'd4:    return m_hist[S-1];
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         m_rise = '0;
         m_fall = '0;
         m_pend = '0;
         m_evt  = '0;
         m_hist.delete();
         for (int i = 0; i <= S; i++) m_hist.push_back('0);
      end else begin
         logic [N-1:0] lvl, old, hw, sw, clr;
         logic         wr;
         lvl = m_hist[S-1];
         old = m_hist[S];
         hw  = (lvl & ~old & m_rise) | (~lvl & old & m_fall);
         wr  = PSEL && PENABLE && PWRITE;
         sw  = (wr && PADDR[4:2] == 3'd3) ? PWDATA : '0;
         clr = (wr && PADDR[4:2] == 3'd2) ? PWDATA : '0;
         m_evt  = hw | sw;
         m_pend = (m_pend & ~clr) | m_evt;
         if (wr && PADDR[4:2] == 3'd0) m_rise = PWDATA;
         if (wr && PADDR[4:2] == 3'd1) m_fall = PWDATA;
         m_hist.push_front(evt);
         void'(m_hist.pop_back());
      end
   end

   // Per-cycle comparison of the outputs against the model, plus pulse counting.
   always @(posedge HCLK) begin
      #1;
      if (HRESETn && cmp_on) begin
         chk("event_o", event_o, m_evt);
         chk("irq_o", irq_o, m_pend);
         for (int i = 0; i < N; i++) if (event_o[i]) pcnt[i]++;
      end
   end

   task automatic clr_cnt();
      for (int i = 0; i < N; i++) pcnt[i] = 0;
   endtask

   task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge HCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(negedge HCLK);
      PENABLE = 1'b1;
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d);
      @(negedge HCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
      #1;
      d = PRDATA;
      chk($sformatf("read_%h", a), PRDATA, m_read(a));
      @(negedge HCLK);
      PENABLE = 1'b1;
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      logic [31:0]   d;
      logic [AW-1:0] offs [5];
      int            others;
      offs[0] = 12'h000; offs[1] = 12'h004; offs[2] = 12'h008;
      offs[3] = 12'h00C; offs[4] = 12'h010;
      clr_cnt();
      cmp_on = 1'b1;
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;

      // Reset state
      for (int i = 0; i < 5; i++) begin
         apb_read(offs[i], d);
         chk("reset_reg", d, 32'h0);
      end
      chk("reset_event", event_o, 32'h0);
      chk("reset_irq", irq_o, 32'h0);
      chk("pready", {31'h0, PREADY}, 32'h1);
      chk("pslverr", {31'h0, PSLVERR}, 32'h0);

      // Rising edge on line 0: pulse lands three edges after the drive
      apb_write(12'h000, 32'h1);
      clr_cnt();
      evt[0] = 1'b1;
      repeat (2) @(posedge HCLK);
      #1 chk("rise_E2", {31'h0, event_o[0]}, 32'h0);
      @(posedge HCLK);
      #1 chk("rise_E3", {31'h0, event_o[0]}, 32'h1);
      @(posedge HCLK);
      #1 chk("rise_E4", {31'h0, event_o[0]}, 32'h0);
      repeat (3) @(negedge HCLK);
      chk("rise_cnt", pcnt[0], 32'd1);
      apb_read(12'h008, d);
      chk("rise_pend", d, 32'h1);
      chk("rise_irq", {31'h0, irq_o[0]}, 32'h1);
      apb_read(12'h010, d);
      chk("level", d, 32'h1);

      // Clear with no concurrent event
      apb_write(12'h008, 32'h1);
      chk("w1c_irq", {31'h0, irq_o[0]}, 32'h0);
      apb_read(12'h008, d);
      chk("w1c_pend", d, 32'h0);

      // Falling-only detection on line 31
      apb_write(12'h000, 32'h0);
      apb_write(12'h004, 32'h8000_0000);
      clr_cnt();
      evt[31] = 1'b1;
      repeat (4) @(negedge HCLK);
      evt[31] = 1'b0;
      repeat (4) @(negedge HCLK);
      evt[31] = 1'b1;
      repeat (8) @(negedge HCLK);
      chk("fall_cnt", pcnt[31], 32'd1);
      apb_read(12'h008, d);
      chk("fall_pend", d, 32'h8000_0000);

      // Clear of bit 0 commits on the same edge its new rise is detected
      apb_write(12'h000, 32'h1);
      evt[0] = 1'b0;
      repeat (5) @(negedge HCLK);
      evt[0] = 1'b1;
      apb_write(12'h008, 32'h1);
      apb_read(12'h008, d);
      chk("set_over_clr", d, 32'h8000_0001);

      // Software set
      apb_write(12'h008, 32'hFFFF_FFFF);
      clr_cnt();
      apb_write(12'h00C, 32'h0000_0C00);
      repeat (2) @(negedge HCLK);
      others = 0;
      for (int i = 0; i < N; i++) if (i != 10 && i != 11) others += pcnt[i];
      chk("swset_cnt10", pcnt[10], 32'd1);
      chk("swset_cnt11", pcnt[11], 32'd1);
      chk("swset_others", others, 32'd0);
      apb_read(12'h008, d);
      chk("swset_pend", d, 32'h0000_0C00);
      apb_read(12'h00C, d);
      chk("swset_read", d, 32'h0);
      apb_read(12'h01C, d);
      chk("unmapped", d, 32'h0);

      // Randomized traffic
      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 4))
            0: begin
               evt = evt ^ ($urandom & $urandom & $urandom);
               @(negedge HCLK);
            end
            1: apb_write(AW'($urandom_range(0, 5) * 4), $urandom);
            2: apb_write(12'h00C, 32'h1 << $urandom_range(0, 31));
            3: apb_read(AW'($urandom_range(0, 7) * 4), d);
            default: repeat ($urandom_range(1, 4)) @(negedge HCLK);
         endcase
      end

      // Asynchronous reset with everything pending
      apb_write(12'h00C, 32'hFFFF_FFFF);
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = 12'h008;
      #1;
      chk("pre_rst_event", event_o, 32'hFFFF_FFFF);
      chk("pre_rst_irq", irq_o, 32'hFFFF_FFFF);
      chk("pre_rst_prdata", PRDATA, 32'hFFFF_FFFF);
      HRESETn = 1'b0;
      #1;
      chk("rst_event", event_o, 32'h0);
      chk("rst_irq", irq_o, 32'h0);
      chk("rst_prdata", PRDATA, 32'h0);
      repeat (3) @(negedge HCLK);
      PSEL = 1'b0;
      HRESETn = 1'b1;
      repeat (6) @(negedge HCLK);
      chk("post_rst_irq", irq_o, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
